rd_burst_sched: RTL and testbench

- Round-robin scheduler that shares one 5-bit buffer read pointer between NREQ requesters.
- Each grant runs a fixed-length read burst: the pointer advances once per cycle and signals a wrap (overflow).
- Sits between client request lines and the buffer read port.
- Replaces ad-hoc latch-based enable sequencing with a registered FSM.

---
 rtl/rd_burst_sched_pkg.sv | 28 ++
 rtl/rd_burst_sched_rr_pick.sv | 36 +++
 rtl/rd_burst_sched.sv | 150 +++++++++++++++
 tb/tb_rd_burst_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rd_burst_sched_pkg.sv
// Shared types and helpers for the read-burst scheduler.
package rd_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Default widths used when the top is instantiated without overrides.
    localparam int DEF_PTR_W   = 5;
    localparam int DEF_BURST_W = 3;

    // Beats in a burst for a given length field; 0 encodes the maximum,
    // 2**burst_w, so every field value describes a non-empty burst.
    function automatic int unsigned burst_beats(input int unsigned len,
                                                input int unsigned burst_w);
        int unsigned beats;
        beats = len;
        if (len == 0) begin
            beats = 32'd1 << burst_w;
        end
        return beats;
    endfunction

endpackage

// File: rtl/rd_burst_sched_rr_pick.sv
// Combinational round-robin picker: searches req starting just after the
// previous winner and wrapping, returning the first set bit.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_gnt,
    output logic [NREQ-1:0]  winner_oh,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // Walk the NREQ positions after last_gnt; the previous winner is checked
    // last so it only wins again when nobody else is asking.
    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        found      = 1'b0;
        idx        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDX_W'((int'(last_gnt) + k) % NREQ);
            if (!found && req[idx]) begin
                found          = 1'b1;
                winner_idx     = idx;
                winner_oh[idx] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rd_burst_sched.sv
// Round-robin read-burst scheduler sharing one buffer read pointer between
// NREQ requesters. Each grant runs a fixed-length burst, followed by one dead
// cycle before the next arbitration.
module rd_burst_sched
    import rd_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int PTR_W   = DEF_PTR_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ready,
    input  logic [NREQ-1:0]    req,
    input  logic [BURST_W-1:0] cfg_burst_len,
    output logic [NREQ-1:0]    gnt,
    output logic               rd_en,
    output logic [PTR_W-1:0]   read_pointer,
    output logic               overflow,
    output logic               busy,
    output logic               done
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = BURST_W + 1;

    state_t           state_reg, state_next;
    logic [NREQ-1:0]  gnt_reg;
    logic [IDX_W-1:0] last_gnt_reg;
    logic [CNT_W-1:0] len_reg;
    logic [CNT_W-1:0] beat_cnt_reg;
    logic [PTR_W-1:0] ptr_reg;

    logic [NREQ-1:0]  pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic             granted_req;
    logic             last_beat;
    logic             beat;
    logic             burst_end;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .last_gnt   (last_gnt_reg),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    // The owner still holding its request is what makes a BURST cycle a beat;
    // other requesters' lines are masked off by the registered grant.
    assign granted_req = |(req & gnt_reg);
    assign last_beat   = (beat_cnt_reg == (len_reg - CNT_W'(1)));

    // Next-state and per-cycle strobes; a dropped request ends the burst
    // without consuming a pointer address.
    always_comb begin
        state_next = state_reg;
        beat       = 1'b0;
        burst_end  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ready && pick_any) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                state_next = BURST;
            end
            BURST: begin
                if (!granted_req) begin
                    burst_end  = 1'b1;
                    state_next = GAP;
                end else begin
                    beat = 1'b1;
                    if (last_beat) begin
                        burst_end  = 1'b1;
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Grant, round-robin history and burst length, captured at arbitration.
    // last_gnt resets to the top index so requester 0 is searched first.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gnt_reg      <= '0;
            last_gnt_reg <= IDX_W'(NREQ - 1);
            len_reg      <= '0;
        end else begin
            if (state_reg == IDLE && state_next == GRANT) begin
                gnt_reg      <= pick_oh;
                last_gnt_reg <= pick_idx;
                len_reg      <= CNT_W'(burst_beats(int'(cfg_burst_len), BURST_W));
            end else if (state_reg == BURST && state_next == GAP) begin
                gnt_reg <= '0;
            end
        end
    end

    // Beat counter: cleared in GRANT so every burst counts from zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt_reg <= '0;
        end else if (state_reg == GRANT) begin
            beat_cnt_reg <= '0;
        end else if (beat) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
        end
    end

    // Shared read pointer: advances once per beat and wraps naturally; it is
    // deliberately carried across bursts so consecutive bursts read onward.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_reg <= '0;
        end else if (beat) begin
            ptr_reg <= ptr_reg + PTR_W'(1);
        end
    end

    assign gnt          = gnt_reg;
    assign rd_en        = beat;
    assign read_pointer = ptr_reg;
    assign overflow     = beat && (&ptr_reg);
    assign done         = burst_end;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_rd_burst_sched.sv
// Directed bench for rd_burst_sched: reset, back-to-back bursts, round-robin
// order, pointer wrap, abort, reset mid-burst and ready gating.
module tb_rd_burst_sched;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [2:0] cfg_burst_len = 3'd0;
    logic [3:0] gnt;
    logic       rd_en;
    logic [4:0] read_pointer;
    logic       overflow;
    logic       busy;
    logic       done;

    int errors  = 0;
    int checks  = 0;
    int exp_ptr = 0;

    rd_burst_sched #(
        .NREQ    (4),
        .PTR_W   (5),
        .BURST_W (3)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .ready         (ready),
        .req           (req),
        .cfg_burst_len (cfg_burst_len),
        .gnt           (gnt),
        .rd_en         (rd_en),
        .read_pointer  (read_pointer),
        .overflow      (overflow),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called while the DUT is in IDLE (or held in reset) with req/ready set so
    // that the next edge grants g; walks GRANT, nb beats, GAP and IDLE.
    task automatic do_burst(input logic [3:0] g, input int nb, input string tag);
        int start;
        start = exp_ptr;
        tick();
        chk({tag, "_grant_gnt"}, 32'(gnt), 32'(g));
        chk({tag, "_grant_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, "_grant_busy"}, 32'(busy), 32'd1);
        for (int b = 0; b < nb; b++) begin
            tick();
            chk({tag, "_beat_rd_en"}, 32'(rd_en), 32'd1);
            chk({tag, "_beat_gnt"}, 32'(gnt), 32'(g));
            chk({tag, "_beat_ptr"}, 32'(read_pointer), 32'(exp_ptr));
            chk({tag, "_beat_done"}, 32'(done), (b == nb - 1) ? 32'd1 : 32'd0);
            chk({tag, "_beat_ovf"}, 32'(overflow), (exp_ptr == 31) ? 32'd1 : 32'd0);
            exp_ptr = (exp_ptr + 1) % 32;
        end
        tick();
        chk({tag, "_gap_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_gap_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, "_gap_done"}, 32'(done), 32'd0);
        chk({tag, "_gap_busy"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_gnt"}, 32'(gnt), 32'd0);
        $display("burst %s gnt=%b beats=%0d ptr %0d..%0d", tag, g, nb, start, (start + nb - 1) % 32);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_ptr", 32'(read_pointer), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Single requester, 3-beat bursts back to back
        resetn = 1'b1;
        ready = 1'b1;
        req = 4'b0001;
        cfg_burst_len = 3'd3;
        do_burst(4'b0001, 3, "single_a");
        do_burst(4'b0001, 3, "single_b");

        // Fresh reset, then round-robin with all four requesting
        resetn = 1'b0;
        #1;
        chk("rr_rst_ptr", 32'(read_pointer), 32'd0);
        tick();
        resetn = 1'b1;
        req = 4'b1111;
        cfg_burst_len = 3'd1;
        exp_ptr = 0;
        do_burst(4'b0001, 1, "rr0");
        do_burst(4'b0010, 1, "rr1");
        do_burst(4'b0100, 1, "rr2");
        do_burst(4'b1000, 1, "rr3");
        do_burst(4'b0001, 1, "rr4");

        // Advance the pointer to 28, then an 8-beat burst across the wrap
        req = 4'b0001;
        cfg_burst_len = 3'd7;
        do_burst(4'b0001, 7, "pre7");
        cfg_burst_len = 3'd0;
        do_burst(4'b0001, 8, "pre8a");
        do_burst(4'b0001, 8, "pre8b");
        chk("wrap_start_ptr", 32'(read_pointer), 32'd28);
        do_burst(4'b0001, 8, "wrap");

        // Abort: requester 2 drops its request after two beats of five
        req = 4'b1100;
        cfg_burst_len = 3'd5;
        tick();
        chk("abort_grant_gnt", 32'(gnt), 32'b0100);
        tick();
        chk("abort_b0_ptr", 32'(read_pointer), 32'(exp_ptr));
        chk("abort_b0_rd_en", 32'(rd_en), 32'd1);
        exp_ptr = (exp_ptr + 1) % 32;
        tick();
        chk("abort_b1_ptr", 32'(read_pointer), 32'(exp_ptr));
        chk("abort_b1_done", 32'(done), 32'd0);
        exp_ptr = (exp_ptr + 1) % 32;
        tick();
        req = 4'b1000;
        #1;
        chk("abort_rd_en", 32'(rd_en), 32'd0);
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_gnt", 32'(gnt), 32'b0100);
        chk("abort_ptr", 32'(read_pointer), 32'(exp_ptr));
        tick();
        chk("abort_gap_gnt", 32'(gnt), 32'd0);
        chk("abort_gap_rd_en", 32'(rd_en), 32'd0);
        chk("abort_gap_busy", 32'(busy), 32'd1);
        tick();
        chk("abort_idle_busy", 32'(busy), 32'd0);
        $display("burst abort gnt=0100 beats=2 then aborted");
        do_burst(4'b1000, 5, "after_abort");

        // Reset asserted asynchronously during the third beat
        req = 4'b0001;
        tick();
        chk("mrst_grant_gnt", 32'(gnt), 32'b0001);
        tick();
        exp_ptr = (exp_ptr + 1) % 32;
        tick();
        exp_ptr = (exp_ptr + 1) % 32;
        tick();
        chk("mrst_b2_rd_en", 32'(rd_en), 32'd1);
        chk("mrst_b2_ptr", 32'(read_pointer), 32'(exp_ptr));
        #2;
        resetn = 1'b0;
        #1;
        chk("mrst_gnt", 32'(gnt), 32'd0);
        chk("mrst_rd_en", 32'(rd_en), 32'd0);
        chk("mrst_ptr", 32'(read_pointer), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ovf", 32'(overflow), 32'd0);
        $display("reset mid-burst at beat 3");
        tick();
        resetn = 1'b1;
        req = 4'b1001;
        cfg_burst_len = 3'd2;
        exp_ptr = 0;
        do_burst(4'b0001, 2, "post_rst");

        // ready gating: no grant while ready is low
        ready = 1'b0;
        req = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("gate_gnt", 32'(gnt), 32'd0);
            chk("gate_busy", 32'(busy), 32'd0);
        end
        ready = 1'b1;
        do_burst(4'b0010, 2, "gated");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
